// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the inst/data SRAM-like port arbiter.
// FSM states, owner identifiers and SRAM-like transfer sizes.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_prio_sel.sv
// Owner pick: data wins unless inst is waiting and the data run
// has reached its bound.
module sram_like_prio_sel
    import sram_like_arbiter_pkg::*;
(
    input  logic   inst_req_i,
    input  logic   data_req_i,
    input  logic   run_sat_i,
    output owner_e owner_o,
    output logic   any_req_o
);

    logic force_inst;

    assign force_inst = inst_req_i && run_sat_i;
    assign any_req_o  = inst_req_i || data_req_i;

    always_comb begin
        owner_o = OWN_INST;
        unique case (1'b1)
            (data_req_i && !force_inst): owner_o = OWN_DATA;
            default:                     owner_o = OWN_INST;
        endcase
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master port between the inst and data requesters,
// one transaction at a time, with a bounded data run to avoid fetch starvation.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned RUN_W        = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [RUN_W-1:0] run_q, run_d;

    owner_e    sel_owner;
    logic      any_req;
    logic      run_sat;
    logic      own_req;
    logic      aok;
    logic      dok;
    sram_req_t inst_bus;
    sram_req_t data_bus;
    sram_req_t own_bus;

    assign run_sat = (run_q == RUN_MAX);

    sram_like_prio_sel u_prio_sel (
        .inst_req_i (inst_req),
        .data_req_i (data_req),
        .run_sat_i  (run_sat),
        .owner_o    (sel_owner),
        .any_req_o  (any_req)
    );

    assign inst_bus = '{wr: inst_wr, size: inst_size,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_bus = '{wr: data_wr, size: data_size,
                        addr: data_addr, wdata: data_wdata};

    assign own_bus = (owner_q == OWN_DATA) ? data_bus : inst_bus;
    assign own_req = (owner_q == OWN_DATA) ? data_req : inst_req;

    assign wr    = own_bus.wr;
    assign size  = own_bus.size;
    assign addr  = own_bus.addr;
    assign wdata = own_bus.wdata;

    // Read data is not qualified; consumers only look at it with data_ok.
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        run_d   = run_q;
        req     = 1'b0;
        aok     = 1'b0;
        dok     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel_owner;
                    state_d = ADDR;
                    if (sel_owner == OWN_DATA && inst_req) begin
                        run_d = (run_q >= RUN_MAX) ? RUN_MAX
                                                   : run_q + RUN_W'(1);
                    end else begin
                        run_d = '0;
                    end
                end
            end
            ADDR: begin
                req = own_req;
                aok = addr_ok && own_req;
                if (!own_req) begin
                    state_d = IDLE;
                end else if (addr_ok) begin
                    dok     = data_ok;
                    state_d = data_ok ? IDLE : RESP;
                end
            end
            RESP: begin
                dok = data_ok;
                if (data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_addr_ok = aok && (owner_q == OWN_INST);
    assign data_addr_ok = aok && (owner_q == OWN_DATA);
    assign inst_data_ok = dok && (owner_q == OWN_INST);
    assign data_data_ok = dok && (owner_q == OWN_DATA);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a slave model and a
// grant-order/response scoreboard.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam logic [31:0] RST_RDATA = 32'hA5A5_0F0F;

    typedef struct packed {
        logic        side;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;

    sram_like_arbiter #(.MAX_DATA_RUN(4), .RUN_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;

    txn_t iq[$];
    txn_t dq[$];
    txn_t exp_q[$];
    txn_t resp_q[$];

    int ntests = 0;
    int nfail = 0;
    int cyc = 0;
    int n_hs_inst = 0, n_hs_data = 0;
    int used_hs_inst = 0, used_hs_data = 0;
    int aok_cyc = 0, dok_cyc_i = 0, dok_cyc_d = 0;
    int rise_cyc = 0, prev_rise_cyc = 0;
    int n_iaok = 0;
    logic req_prev = 1'b0;
    bit force_dok = 1'b0;
    bit same_cycle = 1'b0;
    int addr_lat = 0, data_lat = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_0001;
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    always @(posedge clk) cyc++;

    // Slave model: addr_ok after addr_lat ADDR cycles, data_ok after
    // data_lat response cycles, or both together in same_cycle mode.
    int acnt = 0, dcnt = 0;
    bit busy = 1'b0;
    logic [31:0] pend_rdata = '0;
    always @(negedge clk) begin
        addr_ok = 1'b0;
        data_ok = force_dok;
        if (!resetn) begin
            busy = 1'b0;
            acnt = 0;
            dcnt = 0;
            rdata = RST_RDATA;
        end else if (busy) begin
            if (dcnt == data_lat) begin
                data_ok = 1'b1;
                rdata = pend_rdata;
                busy = 1'b0;
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end else if (req) begin
            if (acnt == addr_lat) begin
                addr_ok = 1'b1;
                acnt = 0;
                if (same_cycle) begin
                    data_ok = 1'b1;
                    rdata = model_rdata(addr);
                end else begin
                    busy = 1'b1;
                    pend_rdata = model_rdata(addr);
                end
            end else begin
                acnt++;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        txn_t e;
        txn_t r;
        #1;
        if (resetn) begin
            if (req && addr_ok) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_data_side", {31'd0, data_addr_ok},
                        {31'd0, e.side});
                    chk("grant_inst_side", {31'd0, inst_addr_ok},
                        {31'd0, !e.side});
                    chk("addr", addr, e.addr);
                    chk("wr", {31'd0, wr}, {31'd0, e.wr});
                    chk("size", {30'd0, size}, {30'd0, e.size});
                    chk("wdata", wdata, e.wdata);
                    resp_q.push_back(e);
                    aok_cyc = cyc;
                end
            end else if (inst_addr_ok || data_addr_ok) begin
                chk("stray_addr_ok", {30'd0, inst_addr_ok, data_addr_ok},
                    32'd0);
            end
            if (inst_addr_ok) begin
                n_iaok++;
                n_hs_inst++;
            end
            if (data_addr_ok) n_hs_data++;
            if (data_ok) begin
                if (resp_q.size() == 0) begin
                    chk("spurious_data_ok",
                        {30'd0, inst_data_ok, data_data_ok}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("dok_data_side", {31'd0, data_data_ok},
                        {31'd0, r.side});
                    chk("dok_inst_side", {31'd0, inst_data_ok},
                        {31'd0, !r.side});
                    chk("rdata", r.side ? data_rdata : inst_rdata,
                        model_rdata(r.addr));
                    if (r.side) dok_cyc_d = cyc;
                    else dok_cyc_i = cyc;
                end
            end
            if (req && !req_prev) begin
                prev_rise_cyc = rise_cyc;
                rise_cyc = cyc;
            end
        end
        req_prev = req;
    end

    // Requesters: present queue heads, advance after each address handshake.
    always @(posedge clk) begin
        #1;
        if (n_hs_inst != used_hs_inst) begin
            used_hs_inst = n_hs_inst;
            if (iq.size() != 0) void'(iq.pop_front());
        end
        if (n_hs_data != used_hs_data) begin
            used_hs_data = n_hs_data;
            if (dq.size() != 0) void'(dq.pop_front());
        end
        inst_req = (iq.size() != 0);
        if (iq.size() != 0) begin
            inst_wr = iq[0].wr;
            inst_size = iq[0].size;
            inst_addr = iq[0].addr;
            inst_wdata = iq[0].wdata;
        end
        data_req = (dq.size() != 0);
        if (dq.size() != 0) begin
            data_wr = dq[0].wr;
            data_size = dq[0].size;
            data_addr = dq[0].addr;
            data_wdata = dq[0].wdata;
        end
    end

    function automatic txn_t mk(input logic s, input logic w,
                                input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d);
        txn_t t;
        t.side = s;
        t.wr = w;
        t.size = sz;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    task automatic push_req(input txn_t t);
        if (t.side) dq.push_back(t);
        else iq.push_back(t);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || resp_q.size() != 0 ||
                iq.size() != 0 || dq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, {31'd0, n < budget}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        txn_t ta[$];
        int n;
        int iaok0;

        repeat (2) @(negedge clk);
        #2;
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_handshakes", {28'd0, inst_addr_ok, inst_data_ok,
            data_addr_ok, data_data_ok}, 32'd0);
        chk("reset_inst_rdata", inst_rdata, RST_RDATA);
        chk("reset_data_rdata", data_rdata, RST_RDATA);
        #1 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious data_ok in IDLE
        @(posedge clk);
        force_dok = 1'b1;
        @(negedge clk);
        #2;
        chk("idle_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        force_dok = 1'b0;
        repeat (2) @(negedge clk);

        // Inst only
        addr_lat = 1;
        data_lat = 1;
        iaok0 = n_iaok;
        t = mk(1'b0, 1'b0, WORD, 32'hBFC0_0000, 32'h0);
        exp_q.push_back(t);
        push_req(t);
        wait_done("inst_only_done", 40);
        chk("inst_only_resp_lat", dok_cyc_i - aok_cyc, 32'd2);
        chk("inst_addr_ok_pulses", n_iaok - iaok0, 32'd1);

        // Simultaneous requests: data first
        addr_lat = 0;
        data_lat = 0;
        ta.delete();
        ta.push_back(mk(1'b1, 1'b1, WORD, 32'h8000_1000, 32'hDEAD_BEEF));
        ta.push_back(mk(1'b0, 1'b0, WORD, 32'hBFC0_0004, 32'h0));
        foreach (ta[i]) exp_q.push_back(ta[i]);
        foreach (ta[i]) push_req(ta[i]);
        wait_done("simultaneous_done", 40);

        // Starvation bound with both sides held high
        ta.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                ta.push_back(mk(1'b0, 1'b0, WORD,
                                32'hBFC0_0100 + 32'(i * 4), 32'h0));
            else
                ta.push_back(mk(1'b1, i[0], HALF,
                                32'h8000_2000 + 32'(i * 4),
                                32'h1111_0000 + 32'(i)));
        end
        foreach (ta[i]) exp_q.push_back(ta[i]);
        foreach (ta[i]) push_req(ta[i]);
        wait_done("starvation_done", 120);

        // Same-cycle addr_ok/data_ok, back to back
        same_cycle = 1'b1;
        ta.delete();
        ta.push_back(mk(1'b1, 1'b0, BYTE, 32'h8000_3001, 32'h0));
        ta.push_back(mk(1'b1, 1'b1, WORD, 32'h8000_3004, 32'h7777_8888));
        foreach (ta[i]) exp_q.push_back(ta[i]);
        foreach (ta[i]) push_req(ta[i]);
        wait_done("same_cycle_done", 40);
        chk("same_cycle_dok", dok_cyc_d - aok_cyc, 32'd0);
        chk("same_cycle_period", rise_cyc - prev_rise_cyc, 32'd2);
        same_cycle = 1'b0;

        // Mid-transaction contention
        data_lat = 3;
        ta.delete();
        ta.push_back(mk(1'b1, 1'b0, WORD, 32'h8000_4000, 32'h0));
        ta.push_back(mk(1'b0, 1'b0, WORD, 32'hBFC0_0200, 32'h0));
        foreach (ta[i]) exp_q.push_back(ta[i]);
        push_req(ta[0]);
        n = 0;
        while (dq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("contention_data_hs", {31'd0, n < 20}, 32'd1);
        push_req(ta[1]);
        @(negedge clk);
        #2;
        chk("contention_inst_req", {31'd0, inst_req}, 32'd1);
        chk("contention_req_low", {31'd0, req}, 32'd0);
        chk("contention_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
        wait_done("contention_done", 40);
        chk("contention_gap", rise_cyc - dok_cyc_d, 32'd2);

        // Async reset while in RESP
        data_lat = 1;
        t = mk(1'b0, 1'b0, WORD, 32'hBFC0_0300, 32'h0);
        exp_q.push_back(t);
        push_req(t);
        n = 0;
        while (iq.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("areset_inst_hs", {31'd0, n < 20}, 32'd1);
        @(negedge clk);
        #3;
        chk("areset_pre_dok", {31'd0, inst_data_ok}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("areset_req", {31'd0, req}, 32'd0);
        chk("areset_handshakes", {28'd0, inst_addr_ok, inst_data_ok,
            data_addr_ok, data_data_ok}, 32'd0);
        repeat (2) @(negedge clk);
        #3 resetn = 1'b1;
        t = mk(1'b0, 1'b0, WORD, 32'hBFC0_0304, 32'h0);
        exp_q.push_back(t);
        push_req(t);
        wait_done("post_reset_done", 40);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
